// File: rtl/cpu_ctrl.sv
// Instruction-sequencing controller for the Lab 6 CPU: a Moore FSM that walks the
// register-file/ALU datapath through read, execute and write-back for each captured instruction.
module cpu_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       err
);

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_GET_A     = 3'd2,
        S_GET_B     = 3'd3,
        S_EXEC      = 3'd4,
        S_WRITE_REG = 3'd5,
        S_WRITE_IMM = 3'd6
    } state_e;

    localparam logic [4:0] INS_MOV_IMM = 5'b110_10;
    localparam logic [4:0] INS_MOV_REG = 5'b110_00;
    localparam logic [4:0] INS_ADD     = 5'b101_00;
    localparam logic [4:0] INS_CMP     = 5'b101_01;
    localparam logic [4:0] INS_AND     = 5'b101_10;
    localparam logic [4:0] INS_MVN     = 5'b101_11;

    state_e     state_q, state_d;
    logic [4:0] ins_q, ins_d;
    logic       err_q, err_d;

    // State, captured instruction class and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_WAIT;
            ins_q   <= 5'b00000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ins_q   <= ins_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; the instruction is only latched on the WAIT edge that sees s.
    always_comb begin
        state_d = state_q;
        ins_d   = ins_q;
        err_d   = err_q;
        case (state_q)
            S_WAIT: begin
                if (s) begin
                    state_d = S_DECODE;
                    ins_d   = {opcode, op};
                    err_d   = 1'b0;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DECODE: begin
                case (ins_q)
                    INS_MOV_IMM:                 state_d = S_WRITE_IMM;
                    INS_MOV_REG, INS_MVN:        state_d = S_GET_B;
                    INS_ADD, INS_CMP, INS_AND:   state_d = S_GET_A;
                    default: begin
                        state_d = S_WAIT;
                        err_d   = 1'b1;
                    end
                endcase
            end
            S_GET_A: state_d = S_GET_B;
            S_GET_B: state_d = S_EXEC;
            S_EXEC: begin
                if (ins_q == INS_CMP) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_WRITE_REG;
                end
            end
            S_WRITE_REG: state_d = S_WAIT;
            S_WRITE_IMM: state_d = S_WAIT;
            default:     state_d = S_WAIT;
        endcase
    end

    // Moore outputs decoded from the current state and captured class.
    always_comb begin
        w     = 1'b0;
        nsel  = 3'b000;
        loada = 1'b0;
        loadb = 1'b0;
        loadc = 1'b0;
        loads = 1'b0;
        asel  = 1'b0;
        bsel  = 1'b0;
        vsel  = 2'b00;
        write = 1'b0;
        case (state_q)
            S_WAIT: w = 1'b1;
            S_DECODE: begin
                w = 1'b0;
            end
            S_GET_A: begin
                nsel  = 3'b001;
                loada = 1'b1;
            end
            S_GET_B: begin
                nsel  = 3'b100;
                loadb = 1'b1;
            end
            S_EXEC: begin
                asel = (ins_q == INS_MOV_REG) || (ins_q == INS_MVN);
                if (ins_q == INS_CMP) begin
                    loads = 1'b1;
                end else begin
                    loadc = 1'b1;
                end
            end
            S_WRITE_REG: begin
                nsel  = 3'b010;
                vsel  = 2'b00;
                write = 1'b1;
            end
            S_WRITE_IMM: begin
                nsel  = 3'b001;
                vsel  = 2'b01;
                write = 1'b1;
            end
            default: w = 1'b0;
        endcase
    end

    assign err = err_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Scoreboard bench for cpu_ctrl: each stimulus step queues the expected output word for
// the cycle it drives into, and a negedge monitor pops and compares.
module tb_cpu_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w, loada, loadb, loadc, loads, asel, bsel, write, err;
    logic [2:0] nsel;
    logic [1:0] vsel;

    cpu_ctrl dut (
        .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
        .w(w), .nsel(nsel), .loada(loada), .loadb(loadb), .loadc(loadc),
        .loads(loads), .asel(asel), .bsel(bsel), .vsel(vsel), .write(write), .err(err)
    );

    always #5 clk = ~clk;

    // Output word: {w, nsel[2:0], loada, loadb, loadc, loads, asel, bsel, vsel[1:0], write, err}
    localparam logic [13:0] X_WAIT   = 14'b1_000_0000_00_00_0_0;
    localparam logic [13:0] X_DEC    = 14'b0_000_0000_00_00_0_0;
    localparam logic [13:0] X_GETA   = 14'b0_001_1000_00_00_0_0;
    localparam logic [13:0] X_GETB   = 14'b0_100_0100_00_00_0_0;
    localparam logic [13:0] X_EX_LC  = 14'b0_000_0010_00_00_0_0;
    localparam logic [13:0] X_EX_AS  = 14'b0_000_0010_10_00_0_0;
    localparam logic [13:0] X_EX_CMP = 14'b0_000_0001_00_00_0_0;
    localparam logic [13:0] X_WREG   = 14'b0_010_0000_00_00_1_0;
    localparam logic [13:0] X_WIMM   = 14'b0_001_0000_00_01_1_0;
    localparam logic [13:0] ERRB     = 14'b0_000_0000_00_00_0_1;

    logic [13:0] sb_q[$];
    int          label_q[$];
    int          applied = 0;
    int          miscompares = 0;
    int          step_no = 0;

    wire [13:0] got = {w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, err};

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            logic [13:0] exp_v;
            int          lbl;
            exp_v = sb_q.pop_front();
            lbl   = label_q.pop_front();
            applied++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL step%0d outputs got %b expected %b", lbl, got, exp_v);
            end
        end
    end

    task automatic step(input logic r, input logic s_i, input logic [2:0] opc,
                        input logic [1:0] op_i, input logic [13:0] exp_v);
        @(posedge clk);
        #1;
        reset  = r;
        s      = s_i;
        opcode = opc;
        op     = op_i;
        step_no++;
        sb_q.push_back(exp_v);
        label_q.push_back(step_no);
    endtask

    initial begin
        reset = 1'b1; s = 1'b0; opcode = 3'b000; op = 2'b00;
        step(1'b1, 1'b0, 3'b000, 2'b00, X_WAIT);
        step(1'b0, 1'b0, 3'b000, 2'b00, X_WAIT);

        // ADD aborted by reset while in GET_B
        step(1'b0, 1'b1, 3'b101, 2'b00, X_WAIT);
        step(1'b0, 1'b0, 3'b101, 2'b00, X_DEC);
        step(1'b0, 1'b0, 3'b101, 2'b00, X_GETA);
        step(1'b0, 1'b0, 3'b101, 2'b00, X_GETB);
        @(negedge clk);
        #2 reset = 1'b1;
        step(1'b1, 1'b0, 3'b101, 2'b00, X_WAIT);
        step(1'b0, 1'b0, 3'b101, 2'b00, X_WAIT);
        step(1'b0, 1'b0, 3'b101, 2'b00, X_WAIT);
        step(1'b0, 1'b0, 3'b101, 2'b00, X_WAIT);
        step(1'b0, 1'b0, 3'b101, 2'b00, X_WAIT);

        // MOV imm, single-cycle s pulse
        step(1'b0, 1'b1, 3'b110, 2'b10, X_WAIT);
        step(1'b0, 1'b0, 3'b110, 2'b10, X_DEC);
        step(1'b0, 1'b0, 3'b110, 2'b10, X_WIMM);
        step(1'b0, 1'b0, 3'b110, 2'b10, X_WAIT);

        // ADD full sequence
        step(1'b0, 1'b1, 3'b101, 2'b00, X_WAIT);
        step(1'b0, 1'b0, 3'b101, 2'b00, X_DEC);
        step(1'b0, 1'b0, 3'b101, 2'b00, X_GETA);
        step(1'b0, 1'b0, 3'b101, 2'b00, X_GETB);
        step(1'b0, 1'b0, 3'b101, 2'b00, X_EX_LC);
        step(1'b0, 1'b0, 3'b101, 2'b00, X_WREG);
        step(1'b0, 1'b0, 3'b101, 2'b00, X_WAIT);

        // CMP: status load only, no write-back
        step(1'b0, 1'b1, 3'b101, 2'b01, X_WAIT);
        step(1'b0, 1'b0, 3'b101, 2'b01, X_DEC);
        step(1'b0, 1'b0, 3'b101, 2'b01, X_GETA);
        step(1'b0, 1'b0, 3'b101, 2'b01, X_GETB);
        step(1'b0, 1'b0, 3'b101, 2'b01, X_EX_CMP);
        step(1'b0, 1'b0, 3'b101, 2'b01, X_WAIT);

        // MVN with opcode disturbed during GET_B; s pulsed outside WAIT must be ignored
        step(1'b0, 1'b1, 3'b101, 2'b11, X_WAIT);
        step(1'b0, 1'b0, 3'b101, 2'b11, X_DEC);
        step(1'b0, 1'b1, 3'b111, 2'b11, X_GETB);
        step(1'b0, 1'b0, 3'b111, 2'b00, X_EX_AS);
        step(1'b0, 1'b0, 3'b111, 2'b00, X_WREG);
        step(1'b0, 1'b0, 3'b111, 2'b00, X_WAIT);

        // MOV reg with opcode disturbed during GET_B
        step(1'b0, 1'b1, 3'b110, 2'b00, X_WAIT);
        step(1'b0, 1'b0, 3'b110, 2'b00, X_DEC);
        step(1'b0, 1'b0, 3'b111, 2'b00, X_GETB);
        step(1'b0, 1'b0, 3'b111, 2'b00, X_EX_AS);
        step(1'b0, 1'b0, 3'b111, 2'b00, X_WREG);
        step(1'b0, 1'b0, 3'b111, 2'b00, X_WAIT);

        // Illegal code sets err, which survives idle and clears on the next capture
        step(1'b0, 1'b1, 3'b111, 2'b00, X_WAIT);
        step(1'b0, 1'b0, 3'b111, 2'b00, X_DEC);
        step(1'b0, 1'b0, 3'b111, 2'b00, X_WAIT | ERRB);
        step(1'b0, 1'b1, 3'b110, 2'b10, X_WAIT | ERRB);
        step(1'b0, 1'b1, 3'b110, 2'b10, X_DEC);
        step(1'b0, 1'b1, 3'b110, 2'b10, X_WIMM);
        step(1'b0, 1'b1, 3'b110, 2'b10, X_WAIT);
        step(1'b0, 1'b0, 3'b110, 2'b10, X_DEC);
        step(1'b0, 1'b0, 3'b110, 2'b10, X_WIMM);
        step(1'b0, 1'b0, 3'b110, 2'b10, X_WAIT);
        step(1'b0, 1'b0, 3'b110, 2'b10, X_WAIT);

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain timeout pending %0d expected 0", sb_q.size());
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
